requant_relu: RTL
=================

REQUANT_RELU -- requirements
Module: requant_relu

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: width of every memory address.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: level-sampled run request, honoured only in IDLE.
REQ-005 SHALL have port finish, output, 1 bit: one-cycle completion pulse.
REQ-006 SHALL have ports param_intf, bias_intf, input_intf and output_intf, each sp_ram_intf.compute with cs, addr, W_req, W_data, oe and R_data.
- Read behaviour on all four: R_data is valid in the cycle after cs and addr are presented.
REQ-007 SHALL tie oe=1 on all four ports, and W_req=`WRITE_DIS and W_data=0 on param_intf, bias_intf and input_intf.

Function
REQ-008 SHALL implement these states: IDLE, LOAD_PARAM, LOAD_BIAS, STREAM, DRAIN, FINISH.
REQ-009 IDLE->LOAD_PARAM when start=1.
REQ-010 LOAD_PARAM SHALL read param addresses 0, 1 and 2 on counter 0..2 and capture the values on counter 1..3:
- num_row (R) from address 0.
- num_channel (C) from address 1.
- shift from address 2, bits [4:0].
REQ-011 After the counter=3 capture, the next state SHALL be FINISH if R=0 or C=0, otherwise LOAD_BIAS.
REQ-012 LOAD_BIAS SHALL read bias_intf address ch in its first cycle and latch the signed 32-bit bias in its second cycle, then go to STREAM.
REQ-013 STREAM SHALL issue one input_intf read per cycle at address ch*R*R+i, for i=0..R*R-1.
- After the last address: LOAD_BIAS for the next channel, or DRAIN after channel C-1.
REQ-014 Each result SHALL be computed in 34-bit signed arithmetic:
- s = psum + bias + rnd.
- y = s >>> shift (arithmetic shift).
- y<0 -> 0; y>255 -> 255; otherwise y.
REQ-015 output_intf write timing:
- cs, W_req=`WRITE_ENB, addr equal to the input address, and W_data={24'h0,y[7:0]} SHALL all be registered.
- They SHALL be asserted exactly 2 cycles after the corresponding input read.
- Steady-state throughput: 1 element/cycle.
REQ-016 Writes still in flight when STREAM switches to LOAD_BIAS SHALL complete; no element may be dropped or duplicated.
REQ-017 DRAIN SHALL last 2 cycles so that the final write retires, then go to FINISH.
REQ-018 FINISH SHALL assert finish for exactly one cycle, then go to IDLE.
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 param_intf.cs=1 only in LOAD_PARAM, bias_intf.cs=1 only in LOAD_BIAS, and input_intf.cs=1 only in STREAM.

Reset
REQ-021 rst=1 SHALL immediately force the state machine to IDLE, including mid-operation.
REQ-022 rst=1 SHALL immediately force to 0: finish, every cs, every addr, output W_data, ch, the counters, R, C, shift and bias.
REQ-023 rst=1 SHALL immediately force output W_req to `WRITE_DIS and squash any pipelined write.
REQ-024 After rst falls, a new start SHALL run normally.

Configuration
REQ-025 With REQUANT_ROUND_EN defined, rnd SHALL be 1<<(shift-1) when shift>0 and 0 when shift=0 (round half up).
REQ-026 Without REQUANT_ROUND_EN, rnd SHALL be 0 (truncation toward negative infinity), and the rounding adder SHALL be absent.

Verification
REQ-027 Basic clamp: R=2, C=1, shift=0, bias=0, psum {5,-3,300,255} -> output[0..3]={5,0,255,255}; first write 2 cycles after first read; then one finish pulse.
REQ-028 Rounding: R=1, C=1, shift=2, bias=1, psum 5 -> output 2 with REQUANT_ROUND_EN, 1 without.
REQ-029 No wrap: psum 0x7FFFFFFF, bias 1, shift 0 -> output 255, not 0.
REQ-030 Per-channel bias: R=1, C=2, bias {10,-10}, psum {0,5}, shift 0 -> output addr0=10, addr1=0; bias reread between channels.
REQ-031 Empty shape: C=0 -> finish pulses 1 cycle after LOAD_PARAM; output W_req never enabled.
REQ-032 Reset recovery: rst pulse during STREAM of R=4, C=2 -> all outputs 0 and no further writes; a restart with start then produces all 32 correct outputs.

Source files
------------

// File: rtl/requant_relu_if.sv
// sp_ram_intf: single-port RAM link (cs/addr/W_req/W_data/oe in, R_data out).
// R_data is valid the cycle after cs and addr are presented.
`ifndef WRITE_ENB
`define WRITE_ENB 1'b1
`endif
`ifndef WRITE_DIS
`define WRITE_DIS 1'b0
`endif

interface sp_ram_intf #(
  parameter int ADDR_W = 32
) ();
  logic              cs;
  logic [ADDR_W-1:0] addr;
  logic              W_req;
  logic [31:0]       W_data;
  logic              oe;
  logic [31:0]       R_data;

  modport compute (
    output cs, addr, W_req, W_data, oe,
    input  R_data
  );

  modport memory (
    input  cs, addr, W_req, W_data, oe,
    output R_data
  );
endinterface

// File: rtl/requant_relu.sv
// requant_relu: per-channel bias add, shift requantise, ReLU clamp to 0..255.
// Ports: clk, rst (async high), start, finish pulse; param/bias/input RAM
// read ports and output RAM write port (sp_ram_intf.compute).
// Option: define REQUANT_ROUND_EN for round-half-up before the shift.
module requant_relu #(
  parameter int ADDR_W = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic finish,
  sp_ram_intf.compute param_intf,
  sp_ram_intf.compute bias_intf,
  sp_ram_intf.compute input_intf,
  sp_ram_intf.compute output_intf
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_PARAM,
    LOAD_BIAS,
    STREAM,
    DRAIN,
    FINISH
  } state_t;

  state_t state_q, state_d;

  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       num_row_q, num_row_d;
  logic [31:0]       num_ch_q, num_ch_d;
  logic [4:0]        shift_q, shift_d;
  logic [31:0]       bias_q, bias_d;
  logic [31:0]       ch_q, ch_d;
  logic [ADDR_W-1:0] rr_q, rr_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              pipe_vld_q, pipe_vld_d;
  logic [ADDR_W-1:0] pipe_addr_q, pipe_addr_d;
  logic              wr_vld_q, wr_vld_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;

  logic              p_cs, b_cs, i_cs;
  logic [ADDR_W-1:0] p_addr, b_addr, i_addr;

  logic signed [33:0] psum_x;
  logic signed [33:0] bias_x;
  logic signed [33:0] sum;
  logic signed [33:0] shifted;
  logic [7:0]         y_sat;

  assign psum_x = {{2{input_intf.R_data[31]}}, input_intf.R_data};
  assign bias_x = {{2{bias_q[31]}}, bias_q};

`ifdef REQUANT_ROUND_EN
  logic signed [33:0] rnd;
  assign rnd = (shift_q == 5'd0) ? 34'sd0
             : (34'sd1 <<< (shift_q - 5'd1));
  assign sum = psum_x + bias_x + rnd;
`else
  assign sum = psum_x + bias_x;
`endif

  assign shifted = sum >>> shift_q;

  always_comb begin
    y_sat = shifted[7:0];
    if (shifted[33]) begin
      y_sat = 8'd0;
    end else if (|shifted[32:8]) begin
      y_sat = 8'd255;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    num_row_d   = num_row_q;
    num_ch_d    = num_ch_q;
    shift_d     = shift_q;
    bias_d      = bias_q;
    ch_d        = ch_q;
    rr_d        = rr_q;
    idx_d       = idx_q;
    rd_addr_d   = rd_addr_q;
    pipe_vld_d  = 1'b0;
    pipe_addr_d = '0;
    p_cs        = 1'b0;
    p_addr      = '0;
    b_cs        = 1'b0;
    b_addr      = '0;
    i_cs        = 1'b0;
    i_addr      = '0;
    finish      = 1'b0;

    // Output pipe stage: data returned for last cycle's read
    wr_vld_d  = pipe_vld_q;
    wr_addr_d = pipe_vld_q ? pipe_addr_q : '0;
    wr_data_d = pipe_vld_q ? y_sat : 8'd0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD_PARAM;
          cnt_d     = 2'd0;
          ch_d      = '0;
          idx_d     = '0;
          rd_addr_d = '0;
        end
      end
      LOAD_PARAM: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q != 2'd3) begin
          p_cs   = 1'b1;
          p_addr = ADDR_W'(cnt_q);
        end
        case (cnt_q)
          2'd1: num_row_d = param_intf.R_data;
          2'd2: num_ch_d  = param_intf.R_data;
          2'd3: begin
            shift_d = param_intf.R_data[4:0];
            rr_d    = ADDR_W'(num_row_q) * ADDR_W'(num_row_q);
            cnt_d   = 2'd0;
            if (num_row_q == '0 || num_ch_q == '0) begin
              state_d = FINISH;
            end else begin
              state_d = LOAD_BIAS;
            end
          end
          default: ;
        endcase
      end
      LOAD_BIAS: begin
        if (cnt_q == 2'd0) begin
          b_cs   = 1'b1;
          b_addr = ADDR_W'(ch_q);
          cnt_d  = 2'd1;
        end else begin
          bias_d  = bias_intf.R_data;
          cnt_d   = 2'd0;
          idx_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        // Channels are contiguous, so one running address covers ch*R*R+i
        i_cs        = 1'b1;
        i_addr      = rd_addr_q;
        pipe_vld_d  = 1'b1;
        pipe_addr_d = rd_addr_q;
        rd_addr_d   = rd_addr_q + 1'b1;
        idx_d       = idx_q + 1'b1;
        if (idx_q == rr_q - 1'b1) begin
          cnt_d = 2'd0;
          if (ch_q == num_ch_q - 32'd1) begin
            state_d = DRAIN;
          end else begin
            ch_d    = ch_q + 32'd1;
            state_d = LOAD_BIAS;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == 2'd0) begin
          cnt_d = 2'd1;
        end else begin
          cnt_d   = 2'd0;
          state_d = FINISH;
        end
      end
      FINISH: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      num_row_q   <= '0;
      num_ch_q    <= '0;
      shift_q     <= '0;
      bias_q      <= '0;
      ch_q        <= '0;
      rr_q        <= '0;
      idx_q       <= '0;
      rd_addr_q   <= '0;
      pipe_vld_q  <= 1'b0;
      pipe_addr_q <= '0;
      wr_vld_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      num_row_q   <= num_row_d;
      num_ch_q    <= num_ch_d;
      shift_q     <= shift_d;
      bias_q      <= bias_d;
      ch_q        <= ch_d;
      rr_q        <= rr_d;
      idx_q       <= idx_d;
      rd_addr_q   <= rd_addr_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_addr_q <= pipe_addr_d;
      wr_vld_q    <= wr_vld_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign param_intf.cs     = p_cs;
  assign param_intf.addr   = p_addr;
  assign param_intf.W_req  = `WRITE_DIS;
  assign param_intf.W_data = '0;
  assign param_intf.oe     = 1'b1;

  assign bias_intf.cs     = b_cs;
  assign bias_intf.addr   = b_addr;
  assign bias_intf.W_req  = `WRITE_DIS;
  assign bias_intf.W_data = '0;
  assign bias_intf.oe     = 1'b1;

  assign input_intf.cs     = i_cs;
  assign input_intf.addr   = i_addr;
  assign input_intf.W_req  = `WRITE_DIS;
  assign input_intf.W_data = '0;
  assign input_intf.oe     = 1'b1;

  assign output_intf.cs     = wr_vld_q;
  assign output_intf.addr   = wr_addr_q;
  assign output_intf.W_req  = wr_vld_q ? `WRITE_ENB : `WRITE_DIS;
  assign output_intf.W_data = {24'h0, wr_data_q};
  assign output_intf.oe     = 1'b1;

endmodule
